// File: rtl/mem_viewer.sv
// Debug memory viewer: walks a 7-bit read address and captures the returned word, with live refresh while holding.
// Optional change-watch output enabled by defining MEM_VIEWER_WATCH_EN.
module mem_viewer #(
    parameter int unsigned MAX_ADDR = 127,
    parameter int unsigned DWELL    = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        auto_en,
    input  logic        step,
    input  logic        back,
    input  logic        jump,
    input  logic [6:0]  jump_addr,
    output logic [6:0]  sw_addr,
    input  logic [31:0] out_data,
    output logic [6:0]  view_addr,
    output logic [31:0] view_data,
    output logic        view_valid,
`ifdef MEM_VIEWER_WATCH_EN
    output logic        changed,
`endif
    output logic        busy
);

    localparam logic [6:0]  ADDR_LAST  = 7'(MAX_ADDR);
    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  sw_addr_q, sw_addr_d;
    logic [6:0]  view_addr_q, view_addr_d;
    logic [31:0] view_data_q, view_data_d;
    logic        view_valid_q, view_valid_d;
    logic [31:0] dwell_cnt_q, dwell_cnt_d;
    logic        auto_tick_q, auto_tick_d;
    logic        step_prev_q, back_prev_q;

    logic        step_rise, back_rise, auto_fire;
    logic [6:0]  addr_inc, addr_dec, jump_tgt;

    assign step_rise = step & ~step_prev_q;
    assign back_rise = back & ~back_prev_q;
    // The dwell expiry is staged through auto_tick_q so an automatic advance is
    // accepted one HOLD cycle later, exactly like a registered button edge.
    assign auto_fire = auto_en & auto_tick_q;

    assign addr_inc = (sw_addr_q == ADDR_LAST) ? 7'd0 : sw_addr_q + 7'd1;
    assign addr_dec = (sw_addr_q == 7'd0) ? ADDR_LAST : sw_addr_q - 7'd1;
    assign jump_tgt = (jump_addr > ADDR_LAST) ? ADDR_LAST : jump_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sw_addr_q    <= 7'd0;
            view_addr_q  <= 7'd0;
            view_data_q  <= 32'd0;
            view_valid_q <= 1'b0;
            dwell_cnt_q  <= 32'd0;
            auto_tick_q  <= 1'b0;
            step_prev_q  <= 1'b0;
            back_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sw_addr_q    <= sw_addr_d;
            view_addr_q  <= view_addr_d;
            view_data_q  <= view_data_d;
            view_valid_q <= view_valid_d;
            dwell_cnt_q  <= dwell_cnt_d;
            auto_tick_q  <= auto_tick_d;
            step_prev_q  <= step;
            back_prev_q  <= back;
        end
    end

    always_comb begin
        state_d      = state_q;
        sw_addr_d    = sw_addr_q;
        view_addr_d  = view_addr_q;
        view_data_d  = view_data_q;
        view_valid_d = 1'b0;
        dwell_cnt_d  = 32'd0;
        auto_tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                view_data_d  = out_data;
                view_addr_d  = sw_addr_q;
                view_valid_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                view_data_d = out_data;
                // Exactly one event is honoured; any event restarts the dwell interval.
                if (jump) begin
                    sw_addr_d = jump_tgt;
                    state_d   = FETCH;
                end else if (step_rise) begin
                    sw_addr_d = addr_inc;
                    state_d   = FETCH;
                end else if (back_rise) begin
                    sw_addr_d = addr_dec;
                    state_d   = FETCH;
                end else if (auto_fire) begin
                    sw_addr_d = addr_inc;
                    state_d   = FETCH;
                end else if (auto_en) begin
                    if (dwell_cnt_q == DWELL_LAST) begin
                        auto_tick_d = 1'b1;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef MEM_VIEWER_WATCH_EN
    logic changed_q, changed_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    // Sticky flag: a refresh in HOLD saw the word differ from what is displayed.
    always_comb begin
        changed_d = changed_q;
        if (state_q == CAPTURE) begin
            changed_d = 1'b0;
        end else if (state_q == HOLD && out_data != view_data_q) begin
            changed_d = 1'b1;
        end
    end

    assign changed = changed_q;
`endif

    assign sw_addr    = sw_addr_q;
    assign view_addr  = view_addr_q;
    assign view_data  = view_data_q;
    assign view_valid = view_valid_q;
    assign busy       = (state_q == FETCH) || (state_q == CAPTURE);

endmodule

// File: tb/tb_mem_viewer.sv
// Directed bench for mem_viewer: event table plus hand sequences for held buttons, auto dwell, watch and reset aborts.
`timescale 1ns/1ps
module tb_mem_viewer;

    localparam int unsigned MAX_A = 100;
    localparam int unsigned DW    = 4;

    logic        clk = 1'b0;
    logic        rst, auto_en, step, back, jump;
    logic [6:0]  jump_addr, sw_addr, view_addr;
    logic [31:0] out_data, view_data;
    logic        view_valid, busy;
`ifdef MEM_VIEWER_WATCH_EN
    logic        changed;
`endif

    logic [31:0] mem [0:127];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;
    assign out_data = mem[sw_addr];

    mem_viewer #(.MAX_ADDR(MAX_A), .DWELL(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .auto_en    (auto_en),
        .step       (step),
        .back       (back),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .sw_addr    (sw_addr),
        .out_data   (out_data),
        .view_addr  (view_addr),
        .view_data  (view_data),
        .view_valid (view_valid),
`ifdef MEM_VIEWER_WATCH_EN
        .changed    (changed),
`endif
        .busy       (busy)
    );

    typedef struct packed {
        logic       s;
        logic       b;
        logic       j;
        logic [6:0] ja;
        logic [6:0] exp_addr;
    } vec_t;

    vec_t vecs [15];
    int   exp_auto [4];
    int   pulse_addr [4];
    int   pulse_cyc [4];

    function automatic logic [31:0] word_of(input int a);
        return (a == 0) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(a));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge with the DUT in HOLD and step/back low the previous cycle.
    task automatic run_event(input logic s, input logic b, input logic j,
                             input logic [6:0] ja, input logic [6:0] exp, input string tag);
        step = s; back = b; jump = j; jump_addr = ja;
        @(negedge clk);
        step = 1'b0; back = 1'b0; jump = 1'b0;
        check({tag, " sw_addr"}, 32'(sw_addr), 32'(exp));
        check({tag, " busy in fetch"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, " valid before latency"}, 32'(view_valid), 32'd0);
        @(negedge clk);
        check({tag, " valid pulse"}, 32'(view_valid), 32'd1);
        check({tag, " view_addr"}, 32'(view_addr), 32'(exp));
        check({tag, " view_data"}, view_data, word_of(int'(exp)));
        check({tag, " busy in hold"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, " valid one cycle"}, 32'(view_valid), 32'd0);
    endtask

    task automatic count_pulses(input int ncyc, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (view_valid) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, got, cyc;

        for (int i = 0; i < 128; i++) mem[i] = word_of(i);
        rst = 1'b1; auto_en = 1'b0; step = 1'b0; back = 1'b0; jump = 1'b0; jump_addr = 7'd0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 7'd0,   7'd1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 7'd0,   7'd2};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 7'd0,   7'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 7'd0,   7'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 7'd0,   7'd100};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 7'd0,   7'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 7'd5,   7'd5};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 7'd20,  7'd20};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 7'd0,   7'd21};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 7'd0,   7'd20};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 7'h7F,  7'd100};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 7'd100, 7'd100};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 7'd101, 7'd100};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 7'd3,   7'd3};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 7'd5,   7'd5};
        exp_auto = '{99, 100, 0, 1};

        // Reset values, then first scan of address 0
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset sw_addr", 32'(sw_addr), 32'd0);
        check("reset view_addr", 32'(view_addr), 32'd0);
        check("reset view_data", view_data, 32'd0);
        check("reset view_valid", 32'(view_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
`ifdef MEM_VIEWER_WATCH_EN
        check("reset changed", 32'(changed), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("boot busy fetch", 32'(busy), 32'd1);
        @(negedge clk);
        check("boot valid early", 32'(view_valid), 32'd0);
        @(negedge clk);
        check("boot valid pulse", 32'(view_valid), 32'd1);
        check("boot view_addr", 32'(view_addr), 32'd0);
        check("boot view_data", view_data, 32'hDEADBEEF);
        @(negedge clk);
        check("boot valid one cycle", 32'(view_valid), 32'd0);
        $display("boot: view_addr=%0d view_data=0x%0h", view_addr, view_data);

        for (int v = 0; v < 15; v++) begin
            run_event(vecs[v].s, vecs[v].b, vecs[v].j, vecs[v].ja, vecs[v].exp_addr,
                      $sformatf("vec%0d", v));
            $display("vec %0d: step=%0b back=%0b jump=%0b ja=%0d -> sw_addr=%0d view_data=0x%0h",
                     v, vecs[v].s, vecs[v].b, vecs[v].j, vecs[v].ja, sw_addr, view_data);
        end

        // Step held high for 10 cycles advances once
        step = 1'b1;
        count_pulses(10, pulses);
        step = 1'b0;
        begin
            int more;
            count_pulses(4, more);
            pulses += more;
        end
        check("held step pulses", 32'(pulses), 32'd1);
        check("held step sw_addr", 32'(sw_addr), 32'd6);
        $display("held step: pulses=%0d sw_addr=%0d", pulses, sw_addr);

        // Step edge during FETCH is dropped
        jump = 1'b1; jump_addr = 7'd10;
        @(negedge clk);
        jump = 1'b0; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check("fetch-step valid", 32'(view_valid), 32'd1);
        check("fetch-step view_addr", 32'(view_addr), 32'd10);
        count_pulses(5, pulses);
        check("fetch-step extra pulses", 32'(pulses), 32'd0);
        check("fetch-step sw_addr", 32'(sw_addr), 32'd10);
        $display("step in fetch: sw_addr=%0d extra pulses=%0d", sw_addr, pulses);

        // Live refresh in HOLD
        mem[10] = 32'h1234_5678;
        @(negedge clk);
        check("refresh view_data", view_data, 32'h1234_5678);
        check("refresh view_valid", 32'(view_valid), 32'd0);
        mem[10] = word_of(10);
        @(negedge clk);
        $display("refresh: view_data=0x%0h", view_data);

        // Auto mode with wrap at MAX_ADDR
        run_event(1'b0, 1'b0, 1'b1, 7'd98, 7'd98, "auto start");
        auto_en = 1'b1;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (view_valid) begin
                pulse_addr[got] = int'(view_addr);
                pulse_cyc[got]  = cyc;
                got++;
            end
        end
        auto_en = 1'b0;
        check("auto pulse count", 32'(got), 32'd4);
        for (int k = 0; k < got; k++) begin
            check($sformatf("auto addr %0d", k), 32'(pulse_addr[k]), 32'(exp_auto[k]));
            $display("auto pulse %0d: addr=%0d cycle=%0d", k, pulse_addr[k], pulse_cyc[k]);
        end
        for (int k = 1; k < got; k++)
            check($sformatf("auto spacing %0d", k), 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'd7);
        count_pulses(20, pulses);
        check("auto off pulses", 32'(pulses), 32'd0);
        check("auto off sw_addr", 32'(sw_addr), 32'd1);

        // Change watch at address 3
        run_event(1'b0, 1'b0, 1'b1, 7'd3, 7'd3, "watch jump");
`ifdef MEM_VIEWER_WATCH_EN
        check("watch idle changed", 32'(changed), 32'd0);
`endif
        mem[3] = 32'h1;
        @(negedge clk);
        mem[3] = 32'h2;
        @(negedge clk);
        check("watch view_data", view_data, 32'h2);
`ifdef MEM_VIEWER_WATCH_EN
        check("watch changed set", 32'(changed), 32'd1);
`endif
        mem[3] = word_of(3);
        @(negedge clk);
        run_event(1'b1, 1'b0, 1'b0, 7'd0, 7'd4, "watch step");
`ifdef MEM_VIEWER_WATCH_EN
        check("watch changed cleared", 32'(changed), 32'd0);
`endif
        $display("watch: sw_addr=%0d view_data=0x%0h", sw_addr, view_data);

        // Reset during FETCH aborts and rescans from 0
        step = 1'b1;
        @(negedge clk);
        step = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst fetch valid", 32'(view_valid), 32'd0);
        check("rst fetch sw_addr", 32'(sw_addr), 32'd0);
        check("rst fetch busy", 32'(busy), 32'd0);
        check("rst fetch view_data", view_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst fetch valid early", 32'(view_valid), 32'd0);
        @(negedge clk);
        check("rst fetch rescan valid", 32'(view_valid), 32'd1);
        check("rst fetch rescan addr", 32'(view_addr), 32'd0);
        check("rst fetch rescan data", view_data, 32'hDEADBEEF);
        @(negedge clk);
        $display("reset in fetch: view_addr=%0d", view_addr);

        // Reset during CAPTURE produces no pulse
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst capture valid", 32'(view_valid), 32'd0);
        check("rst capture view_addr", 32'(view_addr), 32'd0);
        check("rst capture view_data", view_data, 32'd0);
        rst = 1'b0;
        count_pulses(2, pulses);
        check("rst capture early pulses", 32'(pulses), 32'd0);
        @(negedge clk);
        check("rst capture rescan valid", 32'(view_valid), 32'd1);
        check("rst capture rescan addr", 32'(view_addr), 32'd0);
        $display("reset in capture: view_addr=%0d", view_addr);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
